// File: rtl/regfile_sb.sv
// regfile_sb: clocked register file with a per-register pending-write scoreboard.
// It sits between decode and execute and drives the registered ALU operands and
// the store-data path.
//
// Ports
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   rd_en, rd_addr1, rd_addr2   operand capture request and source register indices
//   imm, alu_src                immediate value and operand-B select (1 = immediate)
//   op_a, op_b, store_data      registered operands; store_data is always register B
//   stall                       combinational hazard flag (a source has a pending producer)
//   iss_valid, iss_dst          issue of an instruction that will write iss_dst
//   wb_en, wb_addr, wb_data     writeback port
//   pending_cnt                 number of registers currently marked busy
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 2**ADDR_W - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] store_data,
  output logic              stall,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              fwd_a;
  logic              fwd_b;
  logic              hit_a;
  logic              hit_b;
  logic              set_fire;
  logic              clr_fire;
  logic              cnt_inc;
  logic              cnt_dec;

  // Effective read values, writeback forwarding and hazard detection.
  always_comb begin
    fwd_a = BYPASS && wb_en && (wb_addr == rd_addr1);
    fwd_b = BYPASS && wb_en && (wb_addr == rd_addr2);

    src_a = regs[rd_addr1];
    if (fwd_a) src_a = wb_data;
    if (rd_addr1 == ZERO_A) src_a = '0;

    src_b = regs[rd_addr2];
    if (fwd_b) src_b = wb_data;
    if (rd_addr2 == ZERO_A) src_b = '0;

    // A producer completing this very cycle is not a hazard when it is forwarded.
    hit_a = busy[rd_addr1] && (rd_addr1 != ZERO_A) && !fwd_a;
    hit_b = busy[rd_addr2] && (rd_addr2 != ZERO_A) && !fwd_b;

    // Register B only matters for stalling when it feeds the ALU; a busy store
    // source with alu_src=1 is resolved upstream.
    stall = rd_en && (hit_a || (hit_b && !alu_src));
  end

  // Scoreboard events for this edge, and their effect on the busy count.
  always_comb begin
    set_fire = iss_valid && !stall && (iss_dst != ZERO_A);
    clr_fire = wb_en && (wb_addr != ZERO_A);

    // The count tracks the number of set busy bits exactly: an issue to an
    // already-busy register adds nothing, a writeback to an idle register
    // removes nothing, and a same-register set+clear leaves the bit set.
    cnt_inc = set_fire && !busy[iss_dst];
    cnt_dec = clr_fire && busy[wb_addr] && !(set_fire && (iss_dst == wb_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_fire) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Clear first, then set: when both hit the same register the new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_fire) busy[wb_addr] <= 1'b0;
      if (set_fire) busy[iss_dst] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      pending_cnt <= pending_cnt + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      pending_cnt <= pending_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
    end else if (rd_en && !stall) begin
      op_a       <= src_a;
      op_b       <= alu_src ? imm : src_b;
      store_data <= src_b;
    end
  end

endmodule
